// File: rtl/sa_write_arbiter.sv
// Slave-side AXI4 write arbiter. It picks between dispatcher AW requests
// round-robin, forwards W beats in the same order the AWs were granted, and
// routes each B response to the dispatcher named by the top bits of its ID.
module sa_write_arbiter #(
  parameter int MST_AMT           = 2,
  parameter int MST_ID_W          = $clog2(MST_AMT),
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int TRANS_WR_RESP_W   = 2,
  parameter int W_ORDER_DEPTH     = 4,
  parameter int S_ID_W            = TRANS_MST_ID_W + MST_ID_W
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESETn_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_AWID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_AWADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]      dsp_AWBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_AWLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  dsp_AWSIZE_i,
  input  logic [MST_AMT-1:0]                    dsp_AWVALID_i,
  output logic [MST_AMT-1:0]                    dsp_AWREADY_o,
  input  logic [DATA_WIDTH*MST_AMT-1:0]         dsp_WDATA_i,
  input  logic [MST_AMT-1:0]                    dsp_WLAST_i,
  input  logic [MST_AMT-1:0]                    dsp_WVALID_i,
  output logic [MST_AMT-1:0]                    dsp_WREADY_o,
  output logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_BID_o,
  output logic [TRANS_WR_RESP_W*MST_AMT-1:0]    dsp_BRESP_o,
  output logic [MST_AMT-1:0]                    dsp_BVALID_o,
  input  logic [MST_AMT-1:0]                    dsp_BREADY_i,
  output logic [S_ID_W-1:0]                     s_AWID_o,
  output logic [ADDR_WIDTH-1:0]                 s_AWADDR_o,
  output logic [TRANS_BURST_W-1:0]              s_AWBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]           s_AWLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]          s_AWSIZE_o,
  output logic                                  s_AWVALID_o,
  input  logic                                  s_AWREADY_i,
  output logic [DATA_WIDTH-1:0]                 s_WDATA_o,
  output logic                                  s_WLAST_o,
  output logic                                  s_WVALID_o,
  input  logic                                  s_WREADY_i,
  input  logic [S_ID_W-1:0]                     s_BID_i,
  input  logic [TRANS_WR_RESP_W-1:0]            s_BRESP_i,
  input  logic                                  s_BVALID_i,
  output logic                                  s_BREADY_o
);

  localparam int PTR_W = $clog2(W_ORDER_DEPTH);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t              state, state_nxt;
  logic [MST_ID_W-1:0] lock_idx, lock_idx_nxt;
  logic [MST_ID_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [MST_ID_W-1:0] rr_pick, rr_cand, grant_idx;
  logic                rr_found;
  logic                aw_vld, aw_push;

  logic [MST_ID_W-1:0] order_mem [W_ORDER_DEPTH];
  logic [PTR_W:0]      wr_ptr, rd_ptr;
  logic                fifo_full, fifo_empty, w_pop;
  logic [MST_ID_W-1:0] head_idx;
  logic [MST_ID_W-1:0] b_idx;

  function automatic logic [MST_ID_W-1:0] next_idx(input logic [MST_ID_W-1:0] idx);
    if (int'(idx) == MST_AMT - 1) return '0;
    return idx + 1'b1;
  endfunction

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head_idx   = order_mem[rd_ptr[PTR_W-1:0]];

  // First requesting master at or after rr_ptr, wrapping upward.
  always_comb begin
    rr_pick  = rr_ptr;
    rr_cand  = '0;
    rr_found = 1'b0;
    for (int i = 0; i < MST_AMT; i++) begin
      rr_cand = MST_ID_W'((int'(rr_ptr) + i) % MST_AMT);
      if (!rr_found && dsp_AWVALID_i[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  // Arbiter next state: IDLE grants combinationally, LOCK freezes a stalled grant.
  always_comb begin
    state_nxt    = state;
    lock_idx_nxt = lock_idx;
    rr_ptr_nxt   = rr_ptr;
    grant_idx    = rr_pick;
    aw_vld       = 1'b0;
    aw_push      = 1'b0;
    case (state)
      IDLE: begin
        if (|dsp_AWVALID_i && !fifo_full) begin
          aw_vld = 1'b1;
          if (s_AWREADY_i) begin
            aw_push    = 1'b1;
            rr_ptr_nxt = next_idx(rr_pick);
          end else begin
            state_nxt    = LOCK;
            lock_idx_nxt = rr_pick;
          end
        end
      end
      LOCK: begin
        grant_idx = lock_idx;
        aw_vld    = 1'b1;
        if (s_AWREADY_i) begin
          aw_push    = 1'b1;
          rr_ptr_nxt = next_idx(lock_idx);
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbiter state, held grant and round-robin pointer.
  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      state    <= IDLE;
      lock_idx <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      lock_idx <= lock_idx_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

  // AW payload mux and per-master ready; everything quiet during reset.
  always_comb begin
    s_AWID_o      = {grant_idx, dsp_AWID_i[int'(grant_idx)*TRANS_MST_ID_W +: TRANS_MST_ID_W]};
    s_AWADDR_o    = dsp_AWADDR_i[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    s_AWBURST_o   = dsp_AWBURST_i[int'(grant_idx)*TRANS_BURST_W +: TRANS_BURST_W];
    s_AWLEN_o     = dsp_AWLEN_i[int'(grant_idx)*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
    s_AWSIZE_o    = dsp_AWSIZE_i[int'(grant_idx)*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
    s_AWVALID_o   = aw_vld & ARESETn_i;
    dsp_AWREADY_o = '0;
    if (aw_vld && ARESETn_i) dsp_AWREADY_o[grant_idx] = s_AWREADY_i;
  end

  // W path follows the oldest granted AW still owed data.
  always_comb begin
    s_WDATA_o    = dsp_WDATA_i[int'(head_idx)*DATA_WIDTH +: DATA_WIDTH];
    s_WLAST_o    = dsp_WLAST_i[head_idx];
    s_WVALID_o   = !fifo_empty && ARESETn_i && dsp_WVALID_i[head_idx];
    dsp_WREADY_o = '0;
    if (!fifo_empty && ARESETn_i) dsp_WREADY_o[head_idx] = s_WREADY_i;
  end

  assign w_pop = s_WVALID_o & s_WREADY_i & s_WLAST_o;

  // Order FIFO pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (aw_push) wr_ptr <= wr_ptr + 1'b1;
      if (w_pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Order FIFO storage records which master owns each accepted AW.
  always_ff @(posedge ACLK_i) begin
    if (aw_push && ARESETn_i) order_mem[wr_ptr[PTR_W-1:0]] <= grant_idx;
  end

  assign b_idx       = s_BID_i[S_ID_W-1 -: MST_ID_W];
  assign dsp_BID_o   = {MST_AMT{s_BID_i[TRANS_MST_ID_W-1:0]}};
  assign dsp_BRESP_o = {MST_AMT{s_BRESP_i}};

  // B routing by ID prefix; an out-of-range prefix is acknowledged and dropped.
  always_comb begin
    dsp_BVALID_o = '0;
    s_BREADY_o   = ARESETn_i;
    if (int'(b_idx) < MST_AMT) begin
      dsp_BVALID_o[b_idx] = s_BVALID_i & ARESETn_i;
      s_BREADY_o          = dsp_BREADY_i[b_idx] & ARESETn_i;
    end
  end

endmodule

// File: tb/tb_sa_write_arbiter.sv
// Directed bench for sa_write_arbiter with a queue-based reference model.
module tb_sa_write_arbiter;

  localparam int MA    = 2;
  localparam int DEPTH = 4;

  logic clk, rstn;
  logic [4:0]  awid_m   [MA];
  logic [31:0] awaddr_m [MA];
  logic [1:0]  awburst_m[MA];
  logic [2:0]  awlen_m  [MA];
  logic [2:0]  awsize_m [MA];
  logic [31:0] wdata_m  [MA];
  logic [1:0]  awvalid, wvalid, wlast, bready;
  logic        s_awready, s_wready, s_bvalid;
  logic [5:0]  s_bid;
  logic [1:0]  s_bresp;

  logic [1:0]  dsp_AWREADY_o, dsp_WREADY_o, dsp_BVALID_o;
  logic [9:0]  dsp_BID_o;
  logic [3:0]  dsp_BRESP_o;
  logic [5:0]  s_AWID_o;
  logic [31:0] s_AWADDR_o, s_WDATA_o;
  logic [1:0]  s_AWBURST_o;
  logic [2:0]  s_AWLEN_o, s_AWSIZE_o;
  logic        s_AWVALID_o, s_WLAST_o, s_WVALID_o, s_BREADY_o;

  int checks = 0;
  int failures = 0;

  sa_write_arbiter dut (
    .ACLK_i(clk), .ARESETn_i(rstn),
    .dsp_AWID_i({awid_m[1], awid_m[0]}),
    .dsp_AWADDR_i({awaddr_m[1], awaddr_m[0]}),
    .dsp_AWBURST_i({awburst_m[1], awburst_m[0]}),
    .dsp_AWLEN_i({awlen_m[1], awlen_m[0]}),
    .dsp_AWSIZE_i({awsize_m[1], awsize_m[0]}),
    .dsp_AWVALID_i(awvalid), .dsp_AWREADY_o(dsp_AWREADY_o),
    .dsp_WDATA_i({wdata_m[1], wdata_m[0]}),
    .dsp_WLAST_i(wlast), .dsp_WVALID_i(wvalid), .dsp_WREADY_o(dsp_WREADY_o),
    .dsp_BID_o(dsp_BID_o), .dsp_BRESP_o(dsp_BRESP_o), .dsp_BVALID_o(dsp_BVALID_o),
    .dsp_BREADY_i(bready),
    .s_AWID_o(s_AWID_o), .s_AWADDR_o(s_AWADDR_o), .s_AWBURST_o(s_AWBURST_o),
    .s_AWLEN_o(s_AWLEN_o), .s_AWSIZE_o(s_AWSIZE_o), .s_AWVALID_o(s_AWVALID_o),
    .s_AWREADY_i(s_awready),
    .s_WDATA_o(s_WDATA_o), .s_WLAST_o(s_WLAST_o), .s_WVALID_o(s_WVALID_o),
    .s_WREADY_i(s_wready),
    .s_BID_i(s_bid), .s_BRESP_i(s_bresp), .s_BVALID_i(s_bvalid), .s_BREADY_o(s_BREADY_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue of granted masters, round-robin start, held grant.
  int mq[$];
  int m_rr = 0;
  int m_held = -1;

  always @(negedge clk) begin
    int  g, h, c, bidx;
    bit  awv, wv, pop;
    if (!rstn) begin
      chk("rst_s_awvalid", s_AWVALID_o, 0);
      chk("rst_dsp_awready", dsp_AWREADY_o, 0);
      chk("rst_s_wvalid", s_WVALID_o, 0);
      chk("rst_dsp_wready", dsp_WREADY_o, 0);
      chk("rst_dsp_bvalid", dsp_BVALID_o, 0);
      chk("rst_s_bready", s_BREADY_o, 0);
      mq.delete();
      m_rr = 0;
      m_held = -1;
    end else begin
      awv = 0;
      g = 0;
      if (m_held >= 0) begin
        awv = 1;
        g = m_held;
      end else if (mq.size() < DEPTH) begin
        for (int i = 0; i < MA; i++) begin
          c = (m_rr + i) % MA;
          if (!awv && awvalid[c]) begin
            awv = 1;
            g = c;
          end
        end
      end
      chk("m_s_awvalid", s_AWVALID_o, awv);
      chk("m_dsp_awready", dsp_AWREADY_o, (awv && s_awready) ? (1 << g) : 0);
      if (awv) begin
        chk("m_s_awid", s_AWID_o, (g << 5) | awid_m[g]);
        chk("m_s_awaddr", s_AWADDR_o, awaddr_m[g]);
        chk("m_s_awburst", s_AWBURST_o, awburst_m[g]);
        chk("m_s_awlen", s_AWLEN_o, awlen_m[g]);
        chk("m_s_awsize", s_AWSIZE_o, awsize_m[g]);
      end
      pop = 0;
      if (mq.size() > 0) begin
        h = mq[0];
        wv = wvalid[h];
        chk("m_s_wvalid", s_WVALID_o, wv);
        chk("m_dsp_wready", dsp_WREADY_o, s_wready ? (1 << h) : 0);
        if (wv) begin
          chk("m_s_wdata", s_WDATA_o, wdata_m[h]);
          chk("m_s_wlast", s_WLAST_o, wlast[h]);
        end
        pop = wv && s_wready && wlast[h];
      end else begin
        chk("m_s_wvalid_empty", s_WVALID_o, 0);
        chk("m_dsp_wready_empty", dsp_WREADY_o, 0);
      end
      bidx = s_bid[5];
      chk("m_dsp_bvalid", dsp_BVALID_o, s_bvalid ? (1 << bidx) : 0);
      chk("m_s_bready", s_BREADY_o, bready[bidx]);
      chk("m_dsp_bid", dsp_BID_o, {s_bid[4:0], s_bid[4:0]});
      chk("m_dsp_bresp", dsp_BRESP_o, {s_bresp, s_bresp});
      if (pop) void'(mq.pop_front());
      if (awv && s_awready) begin
        mq.push_back(g);
        m_rr = (g + 1) % MA;
        m_held = -1;
      end else if (awv) begin
        m_held = g;
      end
    end
  end

  initial begin
    rstn = 1'b0;
    awid_m[0] = 5'h03;          awid_m[1] = 5'h11;
    awaddr_m[0] = 32'h1000_0000; awaddr_m[1] = 32'h2000_0000;
    awburst_m[0] = 2'd1;        awburst_m[1] = 2'd2;
    awlen_m[0] = 3'd0;          awlen_m[1] = 3'd1;
    awsize_m[0] = 3'd2;         awsize_m[1] = 3'd2;
    wdata_m[0] = 32'hA0A0_0000; wdata_m[1] = 32'hB1B1_0000;
    awvalid = 2'b11; s_awready = 1'b1; wvalid = 2'b11; wlast = 2'b11; s_wready = 1'b1;
    s_bvalid = 1'b1; s_bid = 6'h2A; s_bresp = 2'b00; bready = 2'b11;
    #2;
    chk("reset_s_awvalid", s_AWVALID_o, 0);
    chk("reset_dsp_awready", dsp_AWREADY_o, 0);
    chk("reset_dsp_bvalid", dsp_BVALID_o, 0);
    chk("reset_s_bready", s_BREADY_o, 0);
    step();
    step();
    rstn = 1'b1;
    awvalid = 2'b00; s_awready = 1'b0; wvalid = 2'b00; wlast = 2'b00; s_wready = 1'b0;
    s_bvalid = 1'b0;

    // Alternating grants until the order FIFO fills.
    for (int k = 0; k < 4; k++) begin
      step();
      awvalid = 2'b11; s_awready = 1'b1;
      #2;
      chk("alt_grant_msb", s_AWID_o[5], k % 2);
      chk("alt_awready", dsp_AWREADY_o, (k % 2) ? 2'b10 : 2'b01);
    end
    step();
    #2;
    chk("full_awvalid", s_AWVALID_o, 0);
    chk("full_awready", dsp_AWREADY_o, 0);
    step();
    wvalid = 2'b01; wlast = 2'b01; s_wready = 1'b1;
    #2;
    chk("full_pop_wvalid", s_WVALID_o, 1);
    chk("full_pop_wdata", s_WDATA_o, 32'hA0A0_0000);
    step();
    wvalid = 2'b00;
    #2;
    chk("after_pop_awvalid", s_AWVALID_o, 1);
    chk("after_pop_awready", dsp_AWREADY_o, 2'b01);
    for (int k = 0; k < 4; k++) begin
      step();
      awvalid = 2'b00; s_awready = 1'b0; wvalid = 2'b11; wlast = 2'b11;
      #2;
      chk("drain_wdata", s_WDATA_o, (k % 2 == 0) ? 32'hB1B1_0000 : 32'hA0A0_0000);
      chk("drain_wready", dsp_WREADY_o, (k % 2 == 0) ? 2'b10 : 2'b01);
    end
    step();
    #2;
    chk("empty_wvalid", s_WVALID_o, 0);
    chk("empty_wready", dsp_WREADY_o, 0);
    wvalid = 2'b00;

    // Stalled grant to master 1 holds against master 0.
    step();
    awvalid = 2'b10; s_awready = 1'b0;
    #2;
    chk("lock_first_addr", s_AWADDR_o, 32'h2000_0000);
    for (int k = 0; k < 2; k++) begin
      step();
      awvalid = 2'b11;
      #2;
      chk("lock_hold_addr", s_AWADDR_o, 32'h2000_0000);
      chk("lock_hold_id", s_AWID_o, 6'h31);
    end
    step();
    s_awready = 1'b1;
    #2;
    chk("lock_release_ready", dsp_AWREADY_o, 2'b10);
    step();
    awvalid = 2'b01;
    #2;
    chk("after_lock_id", s_AWID_o, 6'h03);
    chk("after_lock_ready", dsp_AWREADY_o, 2'b01);

    // W order: master 1 (two beats) before master 0.
    step();
    awvalid = 2'b00; s_awready = 1'b0; wvalid = 2'b01; wlast = 2'b01; s_wready = 1'b1;
    #2;
    chk("order_m0_stalled", s_WVALID_o, 0);
    chk("order_m0_wready", dsp_WREADY_o, 2'b10);
    step();
    wvalid = 2'b11; wlast = 2'b01; wdata_m[1] = 32'hB1B1_0001;
    #2;
    chk("order_m1_beat0", s_WDATA_o, 32'hB1B1_0001);
    chk("order_m1_last0", s_WLAST_o, 0);
    step();
    wlast = 2'b11; wdata_m[1] = 32'hB1B1_0002;
    #2;
    chk("order_m1_beat1", s_WDATA_o, 32'hB1B1_0002);
    chk("order_m1_last1", s_WLAST_o, 1);
    step();
    #2;
    chk("order_m0_beat", s_WDATA_o, 32'hA0A0_0000);
    chk("order_m0_ready", dsp_WREADY_o, 2'b01);
    step();
    wvalid = 2'b00;
    #2;
    chk("order_done", s_WVALID_o, 0);

    // B routing.
    step();
    s_bid = 6'h2A; s_bresp = 2'b10; s_bvalid = 1'b1; bready = 2'b10;
    #2;
    chk("b_m1_valid", dsp_BVALID_o, 2'b10);
    chk("b_m1_id", dsp_BID_o[9:5], 5'h0A);
    chk("b_m1_resp", dsp_BRESP_o[3:2], 2'b10);
    chk("b_m1_ready", s_BREADY_o, 1);
    step();
    bready = 2'b01;
    #2;
    chk("b_m1_notready", s_BREADY_o, 0);
    step();
    s_bid = 6'h03;
    #2;
    chk("b_m0_valid", dsp_BVALID_o, 2'b01);
    chk("b_m0_ready", s_BREADY_o, 1);
    chk("b_m0_id", dsp_BID_o[4:0], 5'h03);
    step();
    s_bvalid = 1'b0;
    #2;
    chk("b_idle", dsp_BVALID_o, 0);

    // Reset while locked with two entries queued and a burst in flight.
    step();
    awvalid = 2'b11; s_awready = 1'b1;
    step();
    step();
    s_awready = 1'b0; wvalid = 2'b10; wlast = 2'b00;
    #2;
    chk("pre_rst_lock_msb", s_AWID_o[5], 1);
    step();
    #2;
    chk("pre_rst_hold_msb", s_AWID_o[5], 1);
    step();
    rstn = 1'b0;
    #2;
    chk("in_rst_awvalid", s_AWVALID_o, 0);
    chk("in_rst_wvalid", s_WVALID_o, 0);
    step();
    rstn = 1'b1; wvalid = 2'b11; wlast = 2'b11;
    #2;
    chk("post_rst_wvalid", s_WVALID_o, 0);
    chk("post_rst_wready", dsp_WREADY_o, 0);
    chk("post_rst_awvalid", s_AWVALID_o, 1);
    chk("post_rst_grant_msb", s_AWID_o[5], 0);
    step();
    s_awready = 1'b1;
    #2;
    chk("post_rst_awready", dsp_AWREADY_o, 2'b01);
    step();
    awvalid = 2'b00; s_awready = 1'b0;
    #2;
    chk("post_rst_first_w", s_WDATA_o, 32'hA0A0_0000);
    step();
    wvalid = 2'b00;
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
